// File: rtl/hnsn_train_sequencer.sv
// hnsn_train_sequencer: training/recall controller for the HNSN network core.
// Presents stored spike patterns, rewards correct decodes, then scores masked-cue recall.
module hnsn_train_sequencer #(
   parameter logic [7:0] PRESENT_CYC  = 8'd32,
   parameter logic [3:0] SPIKE_PERIOD = 4'd4,
   parameter logic [7:0] REST_CYC     = 8'd16,
   parameter logic [3:0] EPOCHS       = 4'd8,
   parameter logic [7:0] TIMEOUT      = 8'd64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_we,
   input  logic [1:0] cfg_idx,
   input  logic [3:0] cfg_pattern,
   input  logic [7:0] cfg_char,
   input  logic [3:0] cfg_mask,
   input  logic [2:0] num_pat,
   input  logic       start,
   input  logic [7:0] char_in,
   input  logic       char_valid_in,
   output logic [3:0] ext_spike_out,
   output logic       reward_out,
   output logic       busy,
   output logic       done,
   output logic [3:0] epoch_cnt,
   output logic [2:0] hit_count
);
   typedef enum logic [2:0] {
      IDLE, TRAIN_PRES, TRAIN_REST, RECALL_PRES, RECALL_REST, DONE
   } state_t;

   typedef struct packed {
      logic [3:0] pattern;
      logic [7:0] chr;
      logic [3:0] mask;
   } slot_t;

   // Zero-length phases collapse to a single cycle so the FSM can never stall.
   localparam logic [3:0] SP_EFF    = (SPIKE_PERIOD == 4'd0) ? 4'd1 : SPIKE_PERIOD;
   localparam logic [7:0] PRES_LAST = (PRESENT_CYC == 8'd0) ? 8'd0 : PRESENT_CYC - 8'd1;
   localparam logic [7:0] REST_LAST = (REST_CYC == 8'd0) ? 8'd0 : REST_CYC - 8'd1;
   localparam logic [7:0] TO_LAST   = (TIMEOUT == 8'd0) ? 8'd0 : TIMEOUT - 8'd1;

   state_t      state, state_nx;
   slot_t [3:0] slots;
   slot_t       cur;
   logic [7:0]  cyc;
   logic [3:0]  ph;
   logic [1:0]  slot, last_idx;
   logic        rewarded;
   logic        idle_like, match, last_slot, more_epochs;
   logic [4:0]  epoch_inc;

   assign cur         = slots[slot];
   assign idle_like   = (state == IDLE) || (state == DONE);
   assign match       = char_valid_in && (char_in == cur.chr);
   assign last_slot   = (slot == last_idx);
   assign epoch_inc   = {1'b0, epoch_cnt} + 5'd1;
   assign more_epochs = epoch_inc < {1'b0, EPOCHS};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      ext_spike_out = 4'h0;
      busy          = !idle_like;
      done          = (state == DONE);
      case (state)
         IDLE, DONE: begin
            if (start) state_nx = (EPOCHS == 4'd0) ? RECALL_PRES : TRAIN_PRES;
         end
         TRAIN_PRES: begin
            if (ph == 4'd0) ext_spike_out = cur.pattern;
            if (cyc == PRES_LAST) state_nx = TRAIN_REST;
         end
         TRAIN_REST: begin
            if (cyc == REST_LAST)
               state_nx = (!last_slot || more_epochs) ? TRAIN_PRES : RECALL_PRES;
         end
         RECALL_PRES: begin
            if (ph == 4'd0) ext_spike_out = cur.pattern & cur.mask;
            if (char_valid_in || cyc == TO_LAST) state_nx = RECALL_REST;
         end
         RECALL_REST: begin
            if (cyc == REST_LAST) state_nx = last_slot ? DONE : RECALL_PRES;
         end
         default: state_nx = IDLE;
      endcase
   end

   // ph tracks cyc % SP_EFF without a divider; both restart on every state change.
   always_ff @(posedge clk) begin
      if (rst) begin
         slots      <= '0;
         cyc        <= 8'd0;
         ph         <= 4'd0;
         slot       <= 2'd0;
         last_idx   <= 2'd0;
         rewarded   <= 1'b0;
         reward_out <= 1'b0;
         epoch_cnt  <= 4'd0;
         hit_count  <= 3'd0;
      end else begin
         reward_out <= 1'b0;
         if (state_nx != state) begin
            cyc <= 8'd0;
            ph  <= 4'd0;
         end else begin
            if (cyc != 8'hFF) cyc <= cyc + 8'd1;
            ph <= (ph == SP_EFF - 4'd1) ? 4'd0 : ph + 4'd1;
         end

         if (cfg_we && idle_like) slots[cfg_idx] <= {cfg_pattern, cfg_char, cfg_mask};

         if (idle_like && start) begin
            slot      <= 2'd0;
            rewarded  <= 1'b0;
            epoch_cnt <= 4'd0;
            hit_count <= 3'd0;
            if (num_pat == 3'd0)      last_idx <= 2'd0;
            else if (num_pat >= 3'd4) last_idx <= 2'd3;
            else                      last_idx <= 2'(num_pat - 3'd1);
         end

         case (state)
            TRAIN_PRES: begin
               if (match && !rewarded) begin
                  reward_out <= 1'b1;
                  rewarded   <= 1'b1;
               end
            end
            TRAIN_REST: begin
               if (cyc == REST_LAST) begin
                  rewarded <= 1'b0;
                  if (last_slot) begin
                     slot <= 2'd0;
                     if (epoch_cnt != 4'hF) epoch_cnt <= epoch_cnt + 4'd1;
                  end else begin
                     slot <= slot + 2'd1;
                  end
               end
            end
            RECALL_PRES: begin
               if (match && hit_count != 3'd7) hit_count <= hit_count + 3'd1;
            end
            RECALL_REST: begin
               if (cyc == REST_LAST && !last_slot) slot <= slot + 2'd1;
            end
            default: ;
         endcase
      end
   end
endmodule
